// File: rtl/ps2_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | ps2_pkg : shared PS/2 timing constants, command codes, TX states |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package ps2_pkg;

    // Timing at a 50 MHz system clock
    localparam int unsigned PS2_INHIBIT_CYCLES = 5_000;    // 100 us
    localparam int unsigned PS2_SETUP_CYCLES   = 50;       // 1 us
    localparam int unsigned PS2_START_TIMEOUT  = 750_000;  // 15 ms
    localparam int unsigned PS2_PACKET_TIMEOUT = 100_000;  // 2 ms
    localparam int unsigned PS2_TIMER_W        = 20;

    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
    localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_INHIBIT    = 4'd1,
        ST_REQ        = 4'd2,
        ST_WAIT_START = 4'd3,
        ST_SHIFT      = 4'd4,
        ST_WAIT_ACK   = 4'd5,
        ST_WAIT_IDLE  = 4'd6,
        ST_DONE       = 4'd7,
        ST_ERR        = 4'd8
    } ps2_tx_state_t;

    // Frame bits after the start bit, LSB first: data, odd parity, stop
    function automatic logic [9:0] ps2_tx_frame(input logic [7:0] data);
        return {1'b1, ~^data, data};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_sync_edge.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | ps2_sync_edge : 2-flop pin synchronizer with falling-edge detect |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module ps2_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_pin,
    output logic o_sync,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Idle PS/2 lines float high, so reset to 1 to avoid a false edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= i_pin;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_fall = r_prev & ~r_sync;

endmodule
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | ps2_host_tx : PS/2 host-to-device command byte transmitter       |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
    parameter int unsigned SETUP_CYCLES   = PS2_SETUP_CYCLES,
    parameter int unsigned START_TIMEOUT  = PS2_START_TIMEOUT,
    parameter int unsigned PACKET_TIMEOUT = PS2_PACKET_TIMEOUT
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_pull,
    output logic       ps2_dat_pull,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int TW = PS2_TIMER_W;
    localparam logic [TW-1:0] c_inhibit_last = TW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] c_setup_last   = TW'(SETUP_CYCLES - 1);
    localparam logic [TW-1:0] c_start_last   = TW'(START_TIMEOUT - 1);
    localparam logic [TW-1:0] c_packet_last  = TW'(PACKET_TIMEOUT - 1);

    ps2_tx_state_t r_state;
    ps2_tx_state_t w_state_nxt;
    logic [9:0]    r_shift;
    logic [9:0]    w_shift_nxt;
    logic [3:0]    r_bit_cnt;
    logic [3:0]    w_bit_cnt_nxt;
    logic [TW-1:0] r_timer;
    logic          r_dat_pull;
    logic          w_dat_pull_nxt;
    logic          w_timer_clr;
    logic          w_pkt_cur;
    logic          w_pkt_nxt;
    logic          w_clk_sync;
    logic          w_clk_fall;
    logic          w_dat_sync;
    logic          w_dat_fall_unused;

    ps2_sync_edge u_clk_sync (
        .clk    (CLOCK_50),
        .rst    (reset),
        .i_pin  (ps2_clk_in),
        .o_sync (w_clk_sync),
        .o_fall (w_clk_fall)
    );

    ps2_sync_edge u_dat_sync (
        .clk    (CLOCK_50),
        .rst    (reset),
        .i_pin  (ps2_dat_in),
        .o_sync (w_dat_sync),
        .o_fall (w_dat_fall_unused)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_dat_pull_nxt = r_dat_pull;

        case (r_state)
            ST_IDLE: begin
                if (tx_valid) begin
                    w_shift_nxt = ps2_tx_frame(tx_data);
                    w_state_nxt = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                if (r_timer >= c_inhibit_last) begin
                    w_state_nxt    = ST_REQ;
                    w_dat_pull_nxt = 1'b1;  // start bit
                end
            end
            ST_REQ: begin
                if (r_timer >= c_setup_last) begin
                    w_state_nxt = ST_WAIT_START;
                end
            end
            ST_WAIT_START: begin
                if (r_timer >= c_start_last) begin
                    w_state_nxt = ST_ERR;
                end else if (w_clk_fall) begin
                    w_dat_pull_nxt = ~r_shift[0];
                    w_shift_nxt    = {1'b1, r_shift[9:1]};
                    w_bit_cnt_nxt  = 4'd1;
                    w_state_nxt    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // Timeout outranks a coincident clock fall
                if (r_timer >= c_packet_last) begin
                    w_state_nxt = ST_ERR;
                end else if (w_clk_fall) begin
                    w_dat_pull_nxt = ~r_shift[0];
                    w_shift_nxt    = {1'b1, r_shift[9:1]};
                    w_bit_cnt_nxt  = r_bit_cnt + 4'd1;
                    if (r_bit_cnt == 4'd9) begin
                        w_state_nxt = ST_WAIT_ACK;
                    end
                end
            end
            ST_WAIT_ACK: begin
                if (r_timer >= c_packet_last) begin
                    w_state_nxt = ST_ERR;
                end else if (w_clk_fall) begin
                    w_state_nxt = w_dat_sync ? ST_ERR : ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                if (r_timer >= c_packet_last) begin
                    w_state_nxt = ST_ERR;
                end else if (w_clk_sync && w_dat_sync) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE:  w_state_nxt = ST_IDLE;
            ST_ERR:   w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase

        if (w_state_nxt == ST_ERR || w_state_nxt == ST_IDLE) begin
            w_dat_pull_nxt = 1'b0;
        end
    end

    // One packet timer runs from the first fall through ack and line idle
    assign w_pkt_cur = (r_state == ST_SHIFT) || (r_state == ST_WAIT_ACK) ||
                       (r_state == ST_WAIT_IDLE);
    assign w_pkt_nxt = (w_state_nxt == ST_SHIFT) || (w_state_nxt == ST_WAIT_ACK) ||
                       (w_state_nxt == ST_WAIT_IDLE);
    assign w_timer_clr = (w_state_nxt != r_state) && !(w_pkt_cur && w_pkt_nxt);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_dat_pull <= 1'b0;
            r_timer    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_dat_pull <= w_dat_pull_nxt;
            if (w_timer_clr) begin
                r_timer <= '0;
            end else if (r_timer != '1) begin
                r_timer <= r_timer + 1'b1;
            end
        end
    end

    assign tx_ready     = (r_state == ST_IDLE);
    assign busy         = (r_state != ST_IDLE);
    assign ps2_clk_pull = (r_state == ST_INHIBIT) || (r_state == ST_REQ);
    assign ps2_dat_pull = r_dat_pull;
    assign tx_done      = (r_state == ST_DONE);
    assign tx_error     = (r_state == ST_ERR);

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for ps2_host_tx: open-drain PS/2 device model, frame reference model,
// timeout and reset scenarios. Timing parameters are scaled down for run time.
module tb_ps2_host_tx;

    localparam int INH    = 300;
    localparam int SETUP  = 20;
    localparam int STO    = 2000;
    localparam int PKT    = 1500;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       ps2_clk_in;
    logic       ps2_dat_in;
    logic       ps2_clk_pull;
    logic       ps2_dat_pull;
    logic       busy;
    logic       tx_done;
    logic       tx_error;
    logic       dev_clk = 1'b1;
    logic       dev_dat_low = 1'b0;

    int total = 0;
    int bad   = 0;
    int cyc = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0;
    int inh_cnt = 0, req_cnt = 0, nobusy_cnt = 0, done_busy = 0;
    int last_err_cyc = 0;
    int acc_cyc = 0;

    always #10 clk = ~clk;

    // Wired-AND open-drain lines
    assign ps2_clk_in = dev_clk & ~ps2_clk_pull;
    assign ps2_dat_in = ~dev_dat_low & ~ps2_dat_pull;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .SETUP_CYCLES   (SETUP),
        .START_TIMEOUT  (STO),
        .PACKET_TIMEOUT (PKT)
    ) dut (
        .CLOCK_50     (clk),
        .reset        (rst),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .ps2_clk_in   (ps2_clk_in),
        .ps2_dat_in   (ps2_dat_in),
        .ps2_clk_pull (ps2_clk_pull),
        .ps2_dat_pull (ps2_dat_pull),
        .busy         (busy),
        .tx_done      (tx_done),
        .tx_error     (tx_error)
    );

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (tx_done) done_cnt <= done_cnt + 1;
        if (tx_done && busy) done_busy <= done_busy + 1;
        if (tx_error) begin
            err_cnt      <= err_cnt + 1;
            last_err_cyc <= cyc;
        end
        if (tx_done && tx_error) both_cnt <= both_cnt + 1;
        if (ps2_clk_pull && !ps2_dat_pull) inh_cnt <= inh_cnt + 1;
        if (ps2_clk_pull && ps2_dat_pull) req_cnt <= req_cnt + 1;
        if ((ps2_clk_pull || ps2_dat_pull) && !busy) nobusy_cnt <= nobusy_cnt + 1;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int obs, input int lo, input int hi);
        total++;
        assert (obs >= lo && obs <= hi) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // Reference frame: data LSB first, then odd parity, then stop
    function automatic logic [9:0] expect_frame(input logic [7:0] d);
        int ones;
        ones = $countones(d);
        return {1'b1, ((ones % 2) == 0) ? 1'b1 : 1'b0, d};
    endfunction

    task automatic send(input logic [7:0] d, input string tag);
        check({tag, "_ready"}, {31'b0, tx_ready}, 32'd1);
        tx_data  = d;
        tx_valid = 1'b1;
        acc_cyc  = cyc;
        tick();
        tx_valid = 1'b0;
        check({tag, "_busy"}, {31'b0, busy}, 32'd1);
    endtask

    task automatic device_frame(input int n_falls, input bit ack, input int half,
                                output logic [9:0] bits, output bit seen,
                                output int first_fall, output logic start_bit);
        int t;
        bits = '0; seen = 1'b0; first_fall = 0; start_bit = 1'b1; t = 0;
        while (!(ps2_clk_pull == 1'b0 && ps2_dat_pull == 1'b1) && t < INH + SETUP + 100) begin
            tick();
            t++;
        end
        if (ps2_clk_pull == 1'b0 && ps2_dat_pull == 1'b1) seen = 1'b1;
        if (!seen) return;
        start_bit = ps2_dat_in;
        repeat (10) tick();
        for (int i = 1; i <= n_falls; i++) begin
            if (i == 11 && ack) begin
                dev_dat_low = 1'b1;
                repeat (5) tick();
            end
            dev_clk = 1'b0;
            if (i == 1) first_fall = cyc;
            repeat (half) tick();
            if (i <= 10) bits[i-1] = ps2_dat_in;
            dev_clk = 1'b1;
            repeat (half) tick();
            dev_dat_low = 1'b0;
        end
    endtask

    task automatic wait_event(input int done0, input int err0, input int limit);
        int t;
        t = 0;
        while (done_cnt == done0 && err_cnt == err0 && t < limit) begin
            tick();
            t++;
        end
        tick();
    endtask

    task automatic run_ok(input logic [7:0] d, input int half, input string tag);
        logic [9:0] bits;
        bit         seen;
        int         ff;
        logic       sb;
        int inh0, req0, done0, err0, db0;
        inh0 = inh_cnt; req0 = req_cnt; done0 = done_cnt; err0 = err_cnt; db0 = done_busy;
        send(d, tag);
        device_frame(11, 1'b1, half, bits, seen, ff, sb);
        check({tag, "_req_seen"}, {31'b0, seen}, 32'd1);
        wait_event(done0, err0, 400);
        check({tag, "_start"}, {31'b0, sb}, 32'd0);
        check({tag, "_frame"}, {22'b0, bits}, {22'b0, expect_frame(d)});
        check({tag, "_done"}, done_cnt - done0, 32'd1);
        check({tag, "_err"}, err_cnt - err0, 32'd0);
        check({tag, "_inhibit"}, inh_cnt - inh0, INH);
        check({tag, "_setup"}, req_cnt - req0, SETUP);
        check({tag, "_busy_at_done"}, done_busy - db0, 32'd1);
        check({tag, "_idle"}, {29'b0, tx_ready, ps2_clk_pull, ps2_dat_pull}, 32'b100);
    endtask

    initial begin
        logic [9:0] bits;
        bit         seen;
        int         ff;
        logic       sb;
        logic [7:0] rb;
        int inh0, done0, err0;

        repeat (5) tick();
        check("reset_outs", {26'b0, tx_ready, busy, ps2_clk_pull, ps2_dat_pull, tx_done, tx_error},
              32'b100000);
        rst = 1'b0;
        repeat (3) tick();

        run_ok(8'hED, 30, "ed");
        check("ed_frame_lit", {22'b0, expect_frame(8'hED)}, 32'h3ED);
        run_ok(8'h00, 30, "zero");
        run_ok(8'hFF, 30, "ff");
        for (int k = 0; k < 4; k++) begin
            rb = 8'($urandom);
            run_ok(rb, int'($urandom_range(40, 20)), "rnd");
        end

        // Device never clocks
        done0 = done_cnt; err0 = err_cnt;
        send(8'hF4, "noclk");
        wait_event(done0, err0, INH + SETUP + STO + 100);
        check("noclk_err", err_cnt - err0, 32'd1);
        check("noclk_done", done_cnt - done0, 32'd0);
        check_range("noclk_time", last_err_cyc - acc_cyc, INH + SETUP + STO - 4, INH + SETUP + STO + 4);
        check("noclk_pulls", {30'b0, ps2_clk_pull, ps2_dat_pull}, 32'd0);

        // Device never acks
        done0 = done_cnt; err0 = err_cnt;
        send(8'h5A, "noack");
        device_frame(11, 1'b0, 30, bits, seen, ff, sb);
        wait_event(done0, err0, 400);
        check("noack_err", err_cnt - err0, 32'd1);
        check("noack_done", done_cnt - done0, 32'd0);

        // Device stops after bit 4
        done0 = done_cnt; err0 = err_cnt;
        send(8'hA7, "stall");
        device_frame(4, 1'b1, 30, bits, seen, ff, sb);
        wait_event(done0, err0, PKT + 200);
        check("stall_err", err_cnt - err0, 32'd1);
        check_range("stall_time", last_err_cyc - ff, PKT - 4, PKT + 4);
        check("stall_pulls", {30'b0, ps2_clk_pull, ps2_dat_pull}, 32'd0);

        // Request while busy is ignored
        inh0 = inh_cnt; done0 = done_cnt; err0 = err_cnt;
        send(8'h3C, "ign");
        tx_data  = 8'hC1;
        tx_valid = 1'b1;
        repeat (50) tick();
        check("ign_ready_low", {31'b0, tx_ready}, 32'd0);
        tx_valid = 1'b0;
        device_frame(11, 1'b1, 30, bits, seen, ff, sb);
        wait_event(done0, err0, 400);
        check("ign_frame", {22'b0, bits}, {22'b0, expect_frame(8'h3C)});
        repeat (200) tick();
        check("ign_no_resend", inh_cnt - inh0, INH);
        run_ok(8'hC1, 30, "rereq");

        // Reset in the middle of SHIFT
        done0 = done_cnt; err0 = err_cnt;
        send(8'h96, "rst");
        device_frame(5, 1'b1, 30, bits, seen, ff, sb);
        rst = 1'b1;
        tick();
        check("rst_idle", {28'b0, tx_ready, busy, ps2_clk_pull, ps2_dat_pull}, 32'b1000);
        rst = 1'b0;
        repeat (PKT + 100) tick();
        check("rst_no_pulse", (done_cnt - done0) + (err_cnt - err0), 32'd0);

        check("never_both", both_cnt, 32'd0);
        check("pull_without_busy", nobusy_cnt, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
